// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the dcache line-refill path.
//   LINE_W         : cache line width in bits (one memory beat)
//   OFFSET_W       : byte-offset bits inside a line; cleared on memory addresses
//   refill_state_t : refill controller states
// -----------------------------------------------------------------------------
package dcache_pkg;

   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WB   = 3'd1,
      GAP  = 3'd2,
      FILL = 3'd3,
      DONE = 3'd4
   } refill_state_t;

endpackage

// File: rtl/dcache_ack_watchdog.sv
// -----------------------------------------------------------------------------
// dcache_ack_watchdog
// Counts cycles spent waiting for a memory ack and raises a sticky error once
// TIMEOUT_CYCLES waiting cycles have elapsed. Only built when the refill
// controller is compiled with DCACHE_REFILL_TIMEOUT_EN.
//   clk_i  : clock
//   rst_i  : asynchronous active-low reset (only way to clear err_o)
//   clr_i  : restart the count (entry into a waiting state)
//   wait_i : a request is outstanding this cycle
//   err_o  : sticky timeout flag
// -----------------------------------------------------------------------------
module dcache_ack_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic wait_i,
   output logic err_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
         err_o <= 1'b0;
      end else begin
         if (clr_i) begin
            cnt_q <= '0;
         end else if (wait_i && (cnt_q != CNT_MAX)) begin
            // saturate so a long stall cannot wrap the counter
            cnt_q <= cnt_q + 1'b1;
         end
         // the edge that completes the TIMEOUT_CYCLES-th waiting cycle sets err
         if (!clr_i && wait_i && (cnt_q == CNT_LAST)) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_refill_ctrl
// Cache-side initiator for the 256-bit line port to Data_Memory. One request
// per miss: optional write-back of a dirty victim, one idle cycle, then the
// line fill. Returns the fill line with a one-cycle done_o pulse.
//
// Optional feature: define DCACHE_REFILL_TIMEOUT_EN to build an ack watchdog
// that sets a sticky err_o after TIMEOUT_CYCLES cycles without ack. Without
// the macro err_o is constant 0.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   req_i, req_dirty_i           miss request (sampled in IDLE only), dirty flag
//   victim_addr_i, fill_addr_i   victim / missing line byte addresses
//   victim_data_i                victim line contents
//   busy_o                       acceptance through done_o, inclusive
//   done_o, fill_data_o          fill pulse and fetched line (held)
//   err_o                        sticky ack timeout
//   mem_enable_o, mem_write_o    memory request, 1 = write-back / 0 = read
//   mem_addr_o, mem_data_o       line-aligned address, write data
//   mem_ack_i, mem_data_i        completion pulse, read data valid with ack
//   state_o                      current FSM state (debug visibility)
//
// Memory handshake: mem_enable_o is raised with mem_write_o/mem_addr_o/
// mem_data_o already valid and all four stay constant until the edge at which
// mem_ack_i is sampled high; that same edge drops mem_enable_o. Enable then
// stays low for at least one cycle before the next request, which the
// responder uses to restart its latency counter. mem_ack_i outside WB/FILL is
// ignored.
// -----------------------------------------------------------------------------
module dcache_refill_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              req_dirty_i,
   input  logic [ADDR_W-1:0] victim_addr_i,
   input  logic [ADDR_W-1:0] fill_addr_i,
   input  logic [LINE_W-1:0] victim_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [LINE_W-1:0] fill_data_o,
   output logic              err_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output refill_state_t     state_o
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("dcache_refill_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

   refill_state_t     state_q, state_d;
   logic [ADDR_W-1:0] fill_addr_q;
   logic              accept;
   logic              fill_ack;

   assign accept   = (state_q == IDLE) && req_i;
   assign fill_ack = (state_q == FILL) && mem_ack_i;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_i) state_d = req_dirty_i ? WB : FILL;
         WB:      if (mem_ack_i) state_d = GAP;
         GAP:     state_d = FILL;
         FILL:    if (mem_ack_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All memory-side outputs are registered from the next state, so they
   // change exactly on the edge that moves the FSM.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         fill_addr_q  <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         done_o       <= 1'b0;
         fill_data_o  <= '0;
      end else begin
         state_q      <= state_d;
         mem_enable_o <= (state_d == WB) || (state_d == FILL);
         mem_write_o  <= (state_d == WB);
         done_o       <= (state_d == DONE);
         if (accept) begin
            // The victim address and data are held directly in the memory
            // output registers; only the fill address needs its own latch.
            fill_addr_q <= line_align(fill_addr_i);
            mem_addr_o  <= req_dirty_i ? line_align(victim_addr_i) : line_align(fill_addr_i);
            mem_data_o  <= victim_data_i;
         end else if (state_q == GAP) begin
            mem_addr_o  <= fill_addr_q;
         end
         if (fill_ack) begin
            fill_data_o <= mem_data_i;
         end
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign state_o = state_q;

`ifdef DCACHE_REFILL_TIMEOUT_EN
   logic wd_clr;
   logic wd_wait;

   assign wd_wait = (state_q == WB) || (state_q == FILL);
   assign wd_clr  = (state_d != state_q) && ((state_d == WB) || (state_d == FILL));

   dcache_ack_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (wd_clr),
      .wait_i (wd_wait),
      .err_o  (err_o)
   );
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_refill_ctrl
// Self-checking bench for dcache_refill_ctrl. A small line memory answers the
// DUT with a programmable ack latency; a reference memory and an expected
// transaction queue predict every bus transfer, the fill data and latency.
// -----------------------------------------------------------------------------
module tb_dcache_refill_ctrl;
   import dcache_pkg::*;

   localparam int ADDR_W = 32;
   localparam int TXN_W  = 1 + ADDR_W + LINE_W;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              req_i = 1'b0;
   logic              req_dirty_i = 1'b0;
   logic [ADDR_W-1:0] victim_addr_i = '0;
   logic [ADDR_W-1:0] fill_addr_i = '0;
   logic [LINE_W-1:0] victim_data_i = '0;
   logic              busy_o, done_o, err_o;
   logic [LINE_W-1:0] fill_data_o;
   logic              mem_enable_o, mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_i;
   refill_state_t     state_dbg;

   dcache_refill_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(64)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_dirty_i(req_dirty_i),
      .victim_addr_i(victim_addr_i), .fill_addr_i(fill_addr_i),
      .victim_data_i(victim_data_i), .busy_o(busy_o), .done_o(done_o),
      .fill_data_o(fill_data_o), .err_o(err_o), .mem_enable_o(mem_enable_o),
      .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .state_o(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [TXN_W-1:0] obs, input logic [TXN_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] init_line(input int i);
      if (i == 0) return {{(LINE_W-4){1'b0}}, 4'h5};
      if (i == 2) return {32{8'hA5}};
      return {8{32'hC0DE0000 | 32'(i)}};
   endfunction

   // ---------------- memory responder + bus monitor ----------------
   int                lmem = 10;      // 0 = never ack
   logic              spur_ack = 1'b0;
   int                lat_cnt = 0;
   logic [LINE_W-1:0] mem [0:63];
   bit                mem_init = 1'b0;
   logic [TXN_W-1:0]  obs_q[$];
   int                done_cnt = 0;
   int                low_run = 0;
   int                rd_gap = 0;
   logic              prev_en = 1'b0;
   logic [ADDR_W+LINE_W:0] prev_bus = '0;
   logic              stable_err = 1'b0;

   assign mem_ack_i  = spur_ack | (mem_enable_o && (lmem != 0) && (lat_cnt == lmem - 1));
   assign mem_data_i = mem[mem_addr_o[10:5]];

   always @(posedge clk_i) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_line(i);
         mem_init <= 1'b1;
      end else if (mem_enable_o && mem_ack_i && mem_write_o) begin
         mem[mem_addr_o[10:5]] <= mem_data_o;
      end
      if (mem_enable_o && mem_ack_i)
         obs_q.push_back({mem_write_o, mem_addr_o, mem_write_o ? mem_data_o : {LINE_W{1'b0}}});
      if (done_o) done_cnt <= done_cnt + 1;
      lat_cnt <= mem_enable_o ? lat_cnt + 1 : 0;
      if (mem_enable_o) begin
         if (!prev_en && !mem_write_o) rd_gap <= low_run;
         low_run <= 0;
         if (prev_en && ({mem_write_o, mem_addr_o, mem_data_o} != prev_bus)) stable_err <= 1'b1;
      end else begin
         low_run <= low_run + 1;
      end
      prev_en  <= mem_enable_o;
      prev_bus <= {mem_write_o, mem_addr_o, mem_data_o};
   end

   // ---------------- reference model ----------------
   logic [LINE_W-1:0] ref_mem [0:63];
   logic [TXN_W-1:0]  exp_q[$];

   task automatic check_zero(input string tag);
      check({tag, "_enable"}, mem_enable_o, 0);
      check({tag, "_write"}, mem_write_o, 0);
      check({tag, "_addr"}, mem_addr_o, 0);
      check({tag, "_wdata"}, mem_data_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_fill"}, fill_data_o, 0);
      check({tag, "_err"}, err_o, 0);
      check({tag, "_state"}, state_dbg, IDLE);
   endtask

   // ---------------- driver ----------------
   task automatic do_miss(input bit dirty, input logic [31:0] vaddr, input logic [31:0] faddr,
                          input logic [LINE_W-1:0] vdata, input int lm, input bit noisy);
      logic [TXN_W-1:0]  t;
      logic [LINE_W-1:0] exp_fill;
      logic [31:0]       first_addr;
      int                exp_lat, k, done_before;
      bit                seen;
      lmem = lm;
      if (dirty) begin
         exp_q.push_back({1'b1, vaddr & ~32'h1F, vdata});
         ref_mem[vaddr[10:5]] = vdata;
      end
      exp_q.push_back({1'b0, faddr & ~32'h1F, {LINE_W{1'b0}}});
      exp_fill   = ref_mem[faddr[10:5]];
      exp_lat    = dirty ? 2 * lm + 3 : lm + 2;
      first_addr = dirty ? (vaddr & ~32'h1F) : (faddr & ~32'h1F);
      done_before = done_cnt;
      @(negedge clk_i);
      req_i = 1'b1; req_dirty_i = dirty;
      victim_addr_i = vaddr; fill_addr_i = faddr; victim_data_i = vdata;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 4 * lm + 20) begin
         @(negedge clk_i);
         k++;
         if (k == 1) begin
            check("acc_busy", busy_o, 1);
            check("acc_enable", mem_enable_o, 1);
            check("acc_write", mem_write_o, dirty);
            check("acc_addr", mem_addr_o, first_addr);
         end
         // accepted inputs must no longer matter
         victim_addr_i = $urandom; fill_addr_i = $urandom;
         victim_data_i = {8{$urandom}}; req_dirty_i = 1'($urandom_range(0, 1));
         if (noisy) req_i = 1'($urandom_range(0, 1));
         if (done_o) begin
            seen = 1'b1;
            check("latency", k + 1, exp_lat);
            check("fill_data", fill_data_o, exp_fill);
            req_i = 1'b0;
         end
      end
      check("done_seen", seen, 1);
      req_i = 1'b0;
      @(negedge clk_i);
      check("done_pulse", done_o, 0);
      check("idle_busy", busy_o, 0);
      check("fill_held", fill_data_o, exp_fill);
      check("done_count", done_cnt - done_before, 1);
      check("txn_count", obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         t = exp_q.pop_front();
         check("txn", obs_q.pop_front(), t);
      end
      exp_q.delete();
      obs_q.delete();
      if (dirty) check("wb_fill_gap", rd_gap, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_line(i);
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;

      // clean miss, line 2, Lmem = 10
      do_miss(1'b0, 32'h0, 32'h0000_0040, '0, 10, 1'b0);
      // dirty miss: write back line 32, then fill line 0 (holds 5)
      do_miss(1'b1, 32'h0000_0400, 32'h0000_0000, {16{16'h1234}}, 10, 1'b0);
      // misaligned fill address
      do_miss(1'b0, 32'h0, 32'h0000_004C, '0, 3, 1'b0);
      // ack in the first enable cycle
      do_miss(1'b0, 32'h0, 32'h0000_0120, '0, 1, 1'b0);
      do_miss(1'b1, 32'h0000_0260, 32'h0000_0260, {8{32'hFEED_0001}}, 1, 1'b0);

      // spurious ack while idle, then noisy req during the transfer
      @(negedge clk_i);
      spur_ack = 1'b1;
      @(negedge clk_i);
      spur_ack = 1'b0;
      check("spur_state", state_dbg, IDLE);
      check("spur_busy", busy_o, 0);
      check("spur_enable", mem_enable_o, 0);
      check("spur_done", done_o, 0);
      do_miss(1'b0, 32'h0, 32'h0000_0060, '0, 6, 1'b1);

      // reset in the middle of a write-back
      lmem = 10;
      @(negedge clk_i);
      req_i = 1'b1; req_dirty_i = 1'b1;
      victim_addr_i = 32'h0000_0500; fill_addr_i = 32'h0000_0020; victim_data_i = {8{32'hDEAD_BEEF}};
      repeat (3) @(negedge clk_i);
      check("wb_state", state_dbg, WB);
      check("wb_enable", mem_enable_o, 1);
      #1 rst_i = 1'b0;
      req_i = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk_i);
      rst_i = 1'b1;
      do_miss(1'b0, 32'h0, 32'h0000_0500, '0, 4, 1'b0);

      // randomized misses
      for (int i = 0; i < 20; i++)
         do_miss(1'($urandom_range(0, 1)), $urandom, $urandom, {8{$urandom}},
                 $urandom_range(1, 6), 1'($urandom_range(0, 1)));

      // memory never acks
      lmem = 0;
      @(negedge clk_i);
      req_i = 1'b1; req_dirty_i = 1'b0; fill_addr_i = 32'h0000_0080;
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk_i);
         if (k == 1) req_i = 1'b0;
         if (k == 64) check("err_before", err_o, 0);
         if (k == 65) begin
`ifdef DCACHE_REFILL_TIMEOUT_EN
            check("err_timeout", err_o, 1);
`else
            check("err_tied", err_o, 0);
`endif
            check("en_waiting", mem_enable_o, 1);
         end
      end
      #1 rst_i = 1'b0;
      #1 check("to_rst_err", err_o, 0);
      check("to_rst_enable", mem_enable_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      obs_q.delete();
      do_miss(1'b0, 32'h0, 32'h0000_0040, '0, 2, 1'b0);

      check("bus_stable", stable_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_refill_ctrl.md
# dcache_refill_ctrl

Cache-side initiator for the 256-bit line interface to `Data_Memory`. It sits inside `CPU` between the dcache controller and the memory port. On a miss it writes back the dirty victim line when required, then fetches the missing line. It returns the fill line to the cache with a one-cycle `done_o` pulse. It owns the `enable`/`write`/`ack` handshake, so the dcache FSM only issues one request per miss.

## Interface
- `LINE_W`, 256, line width in bits
- `ADDR_W`, 32, byte address width
- `TIMEOUT_CYCLES`, 64, cycles without ack before `err_o` (used only with the macro)
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-low reset
- `req_i`  in  1  miss request; sampled only in IDLE
- `req_dirty_i`  in  1  victim is dirty; write back before fill
- `victim_addr_i`  in  ADDR_W  victim line byte address
- `fill_addr_i`  in  ADDR_W  missing line byte address
- `victim_data_i`  in  LINE_W  victim line contents
- `busy_o`  out  1  high from acceptance until `done_o`, inclusive
- `done_o`  out  1  one-cycle pulse; `fill_data_o` valid
- `fill_data_o`  out  LINE_W  fetched line, held until next `done_o`
- `err_o`  out  1  sticky ack timeout (only with macro; else tied 0)
- `mem_enable_o`  out  1  memory request
- `mem_write_o`  out  1  1 = write-back, 0 = read
- `mem_addr_o`  out  ADDR_W  line-aligned address, bits [4:0] forced to 0
- `mem_data_o`  out  LINE_W  write data
- `mem_ack_i`  in  1  memory completion, one-cycle pulse
- `mem_data_i`  in  LINE_W  read data, valid with `mem_ack_i`

## Operation
- States:
  - IDLE → WB when `req_i & req_dirty_i`.
  - IDLE → FILL when `req_i & ~req_dirty_i`.
  - WB → GAP on ack.
  - GAP → FILL unconditionally (1 cycle).
  - FILL → DONE on ack.
  - DONE → IDLE unconditionally.
- On acceptance, latch `fill_addr_i`, `victim_addr_i` and `victim_data_i`. Later changes on those inputs are ignored.
- WB drives `mem_enable_o = 1`, `mem_write_o = 1`, the latched victim address and the latched victim data.
- FILL drives `mem_enable_o = 1`, `mem_write_o = 0` and the latched fill address.
- `mem_enable_o` is low in IDLE, GAP and DONE. There is at least one low cycle between any two requests; the responder's latency counter depends on it.
- `mem_ack_i` is ignored outside WB and FILL.
- A `req_i` while busy is ignored; it is not queued. The dcache holds `req_i` until it sees `done_o`.
- Memory outputs are registered. Address and write/data are stable for the whole time `mem_enable_o` is high.
- Reset values: all outputs 0, `fill_data_o` 0, state IDLE. Reset asserted mid-transfer drops `mem_enable_o` immediately and discards the transfer.

## Timing
- `req_i` is sampled at edge N. `mem_enable_o` rises after edge N.
- Let the ack be sampled at edge M.
- Clean miss: `fill_data_o` is captured and `done_o` goes high after edge M, for exactly one cycle. `mem_enable_o` falls after edge M.
- Dirty miss: the WB ack at edge W gives GAP in cycle W+1. The FILL request rises after edge W+1.
- Latency:
  - clean miss = Lmem + 2 cycles;
  - dirty miss = 2·Lmem + 3 cycles,
  - where Lmem is the number of edges from enable rise to ack sample.
- Ack arriving in the first cycle of enable is legal.

## Configuration
- `DCACHE_REFILL_TIMEOUT_EN` defined:
  - A counter clears on entry to WB/FILL and increments each cycle while waiting.
  - Reaching `TIMEOUT_CYCLES` sets `err_o`. `err_o` is cleared only by reset.
  - The FSM does not abort; it keeps waiting.
- Macro not defined: no counter is built and `err_o` is constant 0.

## Structure
- Put these in shared package `dcache_pkg`: `LINE_W`, `OFFSET_W = 5`, and enum `refill_state_t` (IDLE, WB, GAP, FILL, DONE).
- Sub-module `dcache_ack_watchdog` (counter plus sticky flag), instantiated only under the macro.

## Test plan
- Clean miss: `fill_addr_i = 0x00000040`, memory line 2 = 0xA5…A5, Lmem = 10 → exactly one read at 0x40. `done_o` arrives 12 cycles after acceptance, with `fill_data_o` = 0xA5…A5.
- Dirty miss: victim 0x00000400 with data 0x1234…; fill 0x00000000, which holds n = 5 → write to line 32 first, `mem_enable_o` low for exactly 1 cycle, then a read of line 0. `fill_data_o = 256'h5`; total 23 cycles at Lmem = 10.
- Misaligned `fill_addr_i = 0x0000004C` → `mem_addr_o = 0x00000040`.
- Spurious `mem_ack_i` in IDLE, plus a second `req_i` during FILL → no state change; exactly one `done_o`.
- `rst_i` low during WB → all outputs 0 asynchronously. After release, a new clean request completes normally.
- With the macro and `TIMEOUT_CYCLES = 64`, memory never acks → `err_o` rises after 64 waiting cycles and `mem_enable_o` stays high. Without the macro, `err_o` stays 0.
